oled_cmd_scheduler: RTL

Shares the single OLED display controller between N_REQ graphics requesters, such as a text renderer and a shape engine. It owns the display power request (on_off), wakes the panel on demand, and picks one pending command per turn by round-robin. It forwards the winning command with the exec/rdy handshake and powers the panel down after an idle timeout. It sits between the requester blocks and the display controller instance.

---
 rtl/oled_cmd_scheduler_pkg.sv | 41 ++++
 rtl/oled_cmd_scheduler_rr_arbiter.sv | 37 +++
 rtl/oled_cmd_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/oled_cmd_scheduler_pkg.sv
// Shared types and helpers for the OLED command scheduler: command codes,
// payload layout and the scheduler FSM encoding.
package oled_cmd_scheduler_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [3:0]   oled_cmd_t;
  typedef byte_t [10:0] payload_t;

  localparam oled_cmd_t CMD_PIXEL = 4'd0;
  localparam oled_cmd_t CMD_LINE  = 4'd1;
  localparam oled_cmd_t CMD_RECT  = 4'd2;
  localparam oled_cmd_t CMD_COPY  = 4'd3;
  localparam oled_cmd_t CMD_FILL  = 4'd4;
  localparam oled_cmd_t CMD_MAX   = CMD_FILL;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAKE,
    ST_READY,
    ST_ISSUE,
    ST_ACK,
    ST_BUSY
  } sched_state_t;

  // Payload length on the wire; 0 marks a code the display does not know.
  function automatic logic [3:0] cmd_nbytes(input oled_cmd_t cmd);
    case (cmd)
      CMD_PIXEL: return 4'd2;
      CMD_LINE:  return 4'd5;
      CMD_RECT:  return 4'd7;
      CMD_COPY:  return 4'd8;
      CMD_FILL:  return 4'd11;
      default:   return 4'd0;
    endcase
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/oled_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin search: first requester above ptr (wrapping)
// wins. The pointer register itself lives in the scheduler.
module rr_arbiter
  import oled_cmd_scheduler_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = cnt_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int   idx;
    logic found;
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (advance && found) grant = N'(1) << grant_idx;
  end

  assign any = |req;

endmodule

// File: rtl/oled_cmd_scheduler.sv
// Shares one OLED display controller between N_REQ requesters: powers the
// panel on demand, round-robins commands onto exec/rdy, powers down when idle.
module oled_cmd_scheduler
  import oled_cmd_scheduler_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int IDLE_TIMEOUT = 100000000,
  parameter int WDOG_CYCLES  = 1000000,
  parameter int OFF_HOLD     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwr_req,
  input  logic [N_REQ-1:0]     req_valid,
  input  oled_cmd_t [N_REQ-1:0] req_cmd,
  input  payload_t [N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]     req_accept,
  output logic [N_REQ-1:0]     req_done,
  output logic [N_REQ-1:0]     req_err,
  output logic                 disp_on_off,
  output logic                 disp_exec,
  output oled_cmd_t            disp_cmd,
  output payload_t             disp_ir,
  input  logic                 disp_rdy,
  output logic                 busy
);

  localparam int PW = cnt_width(N_REQ);
  localparam int IW = cnt_width(IDLE_TIMEOUT);
  localparam int WW = cnt_width(WDOG_CYCLES);
  localparam int HW = cnt_width(OFF_HOLD + 1);

  sched_state_t r_state, w_state_nxt;
  logic [PW-1:0] r_ptr;
  oled_cmd_t     r_cmd;
  payload_t      r_data;
  logic [IW-1:0] r_idle;
  logic [WW-1:0] r_wdog;
  logic [HW-1:0] r_hold;

  logic [N_REQ-1:0] w_grant;
  logic [N_REQ-1:0] w_cur_onehot;
  logic [PW-1:0]    w_gidx;
  logic             w_any;
  logic             w_arb_en;
  logic             w_take;
  logic             w_expire;
  logic             w_idle_tick;
  logic             w_idle_expire;

  assign w_arb_en      = (r_state == ST_READY);
  assign w_take        = w_arb_en && w_any;
  assign w_cur_onehot  = N_REQ'(1) << r_ptr;
  assign w_expire      = (r_wdog == WW'(WDOG_CYCLES - 1));
  assign w_idle_tick   = w_arb_en && !w_any && !pwr_req;
  assign w_idle_expire = (r_idle == IW'(IDLE_TIMEOUT - 1));

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req       (req_valid),
    .ptr       (r_ptr),
    .advance   (w_arb_en),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any       (w_any)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= ST_OFF;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    disp_on_off = 1'b1;
    disp_exec   = 1'b0;
    req_accept  = '0;
    req_done    = '0;
    req_err     = '0;
    unique case (r_state)
      ST_OFF: begin
        disp_on_off = 1'b0;
        if (r_hold == '0 && (pwr_req || w_any)) w_state_nxt = ST_WAKE;
      end
      ST_WAKE: if (disp_rdy) w_state_nxt = ST_READY;
      ST_READY: begin
        if (w_any) begin
          req_accept = w_grant;
          if (cmd_nbytes(req_cmd[w_gidx]) != 4'd0) w_state_nxt = ST_ISSUE;
          else                                     req_err     = w_grant;
        end else if (w_idle_tick && w_idle_expire) begin
          w_state_nxt = ST_OFF;
        end
      end
      ST_ISSUE, ST_ACK, ST_BUSY: begin
        // A stuck display is power-cycled rather than waited on forever.
        if (w_expire) begin
          req_err     = w_cur_onehot;
          w_state_nxt = ST_OFF;
        end else if (r_state == ST_ISSUE && disp_rdy) begin
          disp_exec   = 1'b1;
          w_state_nxt = ST_ACK;
        end else if (r_state == ST_ACK && !disp_rdy) begin
          w_state_nxt = ST_BUSY;
        end else if (r_state == ST_BUSY && disp_rdy) begin
          req_done    = w_cur_onehot;
          w_state_nxt = ST_READY;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  assign busy     = (r_state != ST_OFF) && (r_state != ST_READY);
  assign disp_cmd = r_cmd;
  assign disp_ir  = r_data;

  always_ff @(posedge clk) begin
    // NOTE: hold registers are reset so disp_cmd/disp_ir read 0 out of reset.
    if (rst) begin
      r_ptr  <= '0;
      r_cmd  <= '0;
      r_data <= '0;
    end else if (w_take) begin
      r_ptr  <= w_gidx;
      r_cmd  <= req_cmd[w_gidx];
      r_data <= req_data[w_gidx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= '0;
      r_wdog <= '0;
      r_hold <= HW'(OFF_HOLD);
    end else begin
      r_idle <= (w_idle_tick && !w_idle_expire) ? r_idle + IW'(1) : '0;
      r_wdog <= busy ? r_wdog + WW'(1) : '0;
      if (r_state != ST_OFF && w_state_nxt == ST_OFF) r_hold <= HW'(OFF_HOLD);
      else if (r_state == ST_OFF && r_hold != '0)     r_hold <= r_hold - HW'(1);
    end
  end

endmodule
